// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_INC  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ONE  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_A    = 4'h9;
  localparam logic [3:0] OP_ZERO = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_SRA  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  function automatic logic is_multi_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational datapath for every single-cycle opcode; multi-cycle opcodes
// are handled by the iterative engine in the top.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        flags_o
);

  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum_s;
  logic            c_s;
  logic            v_s;
  logic            zn_en_s;

  // Result and flag selection for the single-cycle opcodes
  always_comb begin
    sum_s   = '0;
    res_o   = '0;
    c_s     = 1'b0;
    v_s     = 1'b0;
    zn_en_s = 1'b1;
    case (op_i)
      OP_INC: begin
        sum_s = {1'b0, b_i} + {{DATA_W{1'b0}}, 1'b1};
        res_o = sum_s[M:0];
        c_s   = sum_s[DATA_W];
        v_s   = ~b_i[M] & res_o[M];
      end
      OP_OR:  res_o = a_i | b_i;
      OP_SUB: begin
        // The extra top bit of the widened difference is exactly the borrow (B < A)
        sum_s = {1'b0, b_i} - {1'b0, a_i};
        res_o = sum_s[M:0];
        c_s   = sum_s[DATA_W];
        v_s   = (b_i[M] ^ a_i[M]) & (res_o[M] ^ b_i[M]);
      end
      OP_XOR:  res_o = a_i ^ b_i;
      OP_ONE:  res_o = {{(DATA_W-1){1'b0}}, 1'b1};
      OP_AND:  res_o = a_i & b_i;
      OP_ADD: begin
        sum_s = {1'b0, a_i} + {1'b0, b_i};
        res_o = sum_s[M:0];
        c_s   = sum_s[DATA_W];
        v_s   = ~(a_i[M] ^ b_i[M]) & (res_o[M] ^ a_i[M]);
      end
      OP_NOT:  res_o = ~a_i;
      OP_B:    res_o = b_i;
      OP_A:    res_o = a_i;
      OP_ZERO: res_o = '0;
      OP_PASS: begin
        res_o   = a_i;
        zn_en_s = 1'b0;
      end
      default: res_o = '0;
    endcase
    flags_o         = 4'b0000;
    flags_o[FLAG_Z] = zn_en_s & (res_o == '0);
    flags_o[FLAG_N] = zn_en_s & res_o[M];
    flags_o[FLAG_C] = c_s;
    flags_o[FLAG_V] = v_s;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake: single-cycle ops finish in one
// clock, shifts and multiply iterate one step per clock in EXEC.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              n,
  output logic              v,
  output logic              busy
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [3:0]          flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sc_q, sc_d;

  logic [DATA_W-1:0]   comb_res_s;
  logic [3:0]          comb_flags_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [DATA_W-1:0]   step_lo_s, step_hi_s;
  logic                step_c_s;
  logic                accept_s;

  alu_seq_comb #(.DATA_W(DATA_W)) u_comb (
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .res_o   (comb_res_s),
    .flags_o (comb_flags_s)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == EXEC);
  assign result    = res_q;
  assign z         = flags_q[FLAG_Z];
  assign c         = flags_q[FLAG_C];
  assign n         = flags_q[FLAG_N];
  assign v         = flags_q[FLAG_V];

  // One iteration of the shift / shift-add engine; lo holds the working
  // value (shift operand or multiplier), hi the upper product half.
  always_comb begin
    step_lo_s = lo_q;
    step_hi_s = hi_q;
    step_c_s  = sc_q;
    mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
    if (cnt_q != '0) begin
      case (op_q)
        OP_SHL: begin
          step_c_s  = lo_q[DATA_W-1];
          step_lo_s = {lo_q[DATA_W-2:0], 1'b0};
        end
        OP_SHR: begin
          step_c_s  = lo_q[0];
          step_lo_s = {1'b0, lo_q[DATA_W-1:1]};
        end
        OP_SRA: begin
          step_c_s  = lo_q[0];
          step_lo_s = {lo_q[DATA_W-1], lo_q[DATA_W-1:1]};
        end
        OP_MUL: begin
          step_hi_s = mul_sum_s[DATA_W:1];
          step_lo_s = {mul_sum_s[0], lo_q[DATA_W-1:1]};
        end
        default: step_lo_s = lo_q;
      endcase
    end else begin
      step_lo_s = lo_q;
    end
  end

  // FSM next-state, operand capture and result/flag update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    if (accept_s) begin
      op_d = op;
      a_d  = a;
      lo_d = b;
      hi_d = '0;
      sc_d = 1'b0;
      if (is_multi_op(op)) begin
        state_d = EXEC;
        cnt_d   = (op == OP_MUL) ? CNT_W'(DATA_W) : CNT_W'(a[SH_W-1:0]);
      end else begin
        state_d = DONE;
        res_d   = comb_res_s;
        flags_d = comb_flags_s;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        EXEC: begin
          lo_d = step_lo_s;
          hi_d = step_hi_s;
          sc_d = step_c_s;
          // A count of 0 or 1 means this is the final EXEC cycle
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d           = '0;
            state_d         = DONE;
            res_d           = step_lo_s;
            flags_d         = 4'b0000;
            flags_d[FLAG_Z] = (step_lo_s == '0);
            flags_d[FLAG_N] = step_lo_s[DATA_W-1];
            flags_d[FLAG_C] = (op_q == OP_MUL) ? (|step_hi_s) : step_c_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
      sc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues hand-computed results, the
// monitor checks each presented result, its latency and its stability.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       z, c, n, v;
  logic       busy;

  typedef struct {
    logic [7:0] res;
    logic [3:0] zcnv;
    int         lat;
    int         acc;
    int         id;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] zcnv;
    int         lat;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   next_id = 0;

  alu_seq #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .c         (c),
    .n         (n),
    .v         (v),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] er, input logic [3:0] ez, input int lat,
                       input bit push, output int waits);
    exp_t e;
    in_valid = 1'b1;
    op = o;
    a  = aa;
    b  = bb;
    #1;
    waits = 0;
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: op %0h never accepted", o);
    end else if (push) begin
      e.res  = er;
      e.zcnv = ez;
      e.lat  = lat;
      e.acc  = cyc + 1;
      e.id   = next_id;
      next_id++;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Monitor: checks each new presentation, then stability while it is held.
  initial begin : monitor
    exp_t cur;
    bit   chk;
    chk = 1'b0;
    cur.res = 8'h00;
    cur.zcnv = 4'h0;
    cur.lat = 0;
    cur.acc = 0;
    cur.id = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk = 1'b0;
      end else begin
        if (out_valid && !chk) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_result: result %0h with empty scoreboard", result);
          end else begin
            cur = q.pop_front();
            if (result !== cur.res || {z, c, n, v} !== cur.zcnv || (cyc - cur.acc + 1) != cur.lat) begin
              bad++;
              $display("FAIL result_%0d: got res=%0h zcnv=%b lat=%0d expected res=%0h zcnv=%b lat=%0d",
                       cur.id, result, {z, c, n, v}, cyc - cur.acc + 1, cur.res, cur.zcnv, cur.lat);
            end
          end
          chk = 1'b1;
        end else if (out_valid && chk) begin
          total++;
          if (result !== cur.res || {z, c, n, v} !== cur.zcnv || (!out_ready && in_ready !== 1'b0)) begin
            bad++;
            $display("FAIL hold_%0d: got res=%0h zcnv=%b in_ready=%b expected res=%0h zcnv=%b in_ready=0",
                     cur.id, result, {z, c, n, v}, in_ready, cur.res, cur.zcnv);
          end
        end
        if (out_valid && out_ready) chk = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  vec_t dir[12];
  vec_t strm[8];

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin : stim
    int w;
    dir[0]  = '{4'h6, 8'h7F, 8'h01, 8'h80, 4'b0011, 1};
    dir[1]  = '{4'h2, 8'h05, 8'h03, 8'hFE, 4'b0110, 1};
    dir[2]  = '{4'h2, 8'h42, 8'h42, 8'h00, 4'b1000, 1};
    dir[3]  = '{4'h2, 8'h01, 8'h80, 8'h7F, 4'b0001, 1};
    dir[4]  = '{4'hD, 8'h03, 8'h90, 8'hF2, 4'b0010, 4};
    dir[5]  = '{4'hD, 8'h00, 8'h90, 8'h90, 4'b0010, 2};
    dir[6]  = '{4'hB, 8'h01, 8'h81, 8'h02, 4'b0100, 2};
    dir[7]  = '{4'hC, 8'h02, 8'h03, 8'h00, 4'b1100, 3};
    dir[8]  = '{4'hE, 8'h0F, 8'h0F, 8'hE1, 4'b0010, 9};
    dir[9]  = '{4'h8, 8'h11, 8'h80, 8'h80, 4'b0010, 1};
    dir[10] = '{4'h9, 8'h00, 8'h55, 8'h00, 4'b1000, 1};
    dir[11] = '{4'hA, 8'h12, 8'h34, 8'h00, 4'b1000, 1};
    strm[0] = '{4'h0, 8'h00, 8'hFF, 8'h00, 4'b1100, 1};
    strm[1] = '{4'h0, 8'h00, 8'h7F, 8'h80, 4'b0011, 1};
    strm[2] = '{4'h1, 8'h0F, 8'hF0, 8'hFF, 4'b0010, 1};
    strm[3] = '{4'h3, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1};
    strm[4] = '{4'h4, 8'h77, 8'h88, 8'h01, 4'b0000, 1};
    strm[5] = '{4'h5, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
    strm[6] = '{4'h7, 8'h00, 8'h12, 8'hFF, 4'b0010, 1};
    strm[7] = '{4'hF, 8'h00, 8'hFF, 8'h00, 4'b0000, 1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 4'h0;
    a = 8'h00;
    b = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {z, c, n, v}, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      issue(dir[i].op, dir[i].a, dir[i].b, dir[i].res, dir[i].zcnv, dir[i].lat, 1'b1, w);
      in_valid = 1'b0;
    end
    drain();

    // Multiply then a held add: the add must wait out all DATA_W EXEC cycles.
    issue(4'hE, 8'h10, 8'h20, 8'h00, 4'b1100, 9, 1'b1, w);
    issue(4'h6, 8'hFF, 8'h01, 8'h00, 4'b1100, 1, 1'b1, w);
    in_valid = 1'b0;
    check("exec_wait_cycles", w, 8);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(strm[i].op, strm[i].a, strm[i].b, strm[i].res, strm[i].zcnv, strm[i].lat, 1'b1, w);
      check("stream_no_stall", w, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply: nothing may be presented.
    issue(4'hE, 8'h0F, 8'h0F, 8'h00, 4'h0, 9, 1'b0, w);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", {z, c, n, v}, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    check("mid_no_result", out_valid, 0);
    check("mid_scoreboard", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
